// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - DMI constants, ROM entry type, sequencer states and command program (trace macro: DMI_TRACE_EN)
package dmi_pkg;

  localparam int DMI_WID = 32;

  // DM register addresses
  localparam logic [6:0] DATA0      = 7'h04;
  localparam logic [6:0] DMCONTROL  = 7'h10;
  localparam logic [6:0] DMSTATUS   = 7'h11;
  localparam logic [6:0] HARTINFO   = 7'h12;
  localparam logic [6:0] ABSTRACTCS = 7'h16;
  localparam logic [6:0] COMMAND    = 7'h17;
  localparam logic [6:0] HALTSUM0   = 7'h40;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSVD  = 2'd3
  } dmi_op_e;

  localparam logic [1:0] RESP_OK     = 2'd0;
  localparam logic [1:0] RESP_FAILED = 2'd2;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  // Abstract register number aliased to the per-hart scratch register
  localparam logic [15:0] REGNO_SCRATCH = 16'h1000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RESP  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  typedef struct packed {
    dmi_op_e              op;
    logic [6:0]           addr;
    logic [DMI_WID-1:0]   data;
  } dmi_entry_t;

  function automatic dmi_entry_t dmi_wr(input logic [6:0] addr, input logic [DMI_WID-1:0] data);
    dmi_entry_t e;
    e.op   = DMI_WRITE;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  function automatic dmi_entry_t dmi_rd(input logic [6:0] addr);
    dmi_entry_t e;
    e.op   = DMI_READ;
    e.addr = addr;
    e.data = '0;
    return e;
  endfunction

  // Command program replayed by the sequencer; unlisted entries are nops
  function automatic dmi_entry_t dmi_program(input logic [31:0] idx);
    dmi_entry_t e;
    e.op   = DMI_NOP;
    e.addr = '0;
    e.data = '0;
    case (idx)
      0:  e = dmi_wr(DMCONTROL, 32'h8000_0000);
      1:  e = dmi_rd(DMCONTROL);
      2:  e = dmi_wr(DMCONTROL, 32'h0000_0001);
      3:  e = dmi_wr(DMCONTROL, 32'h8000_0001);
      4:  e = dmi_rd(DMSTATUS);
      5:  e = dmi_rd(HALTSUM0);
      6:  e = dmi_wr(DATA0, 32'hDEAD_BEEF);
      7:  e = dmi_wr(COMMAND, 32'h0003_1000);
      8:  e = dmi_wr(DATA0, 32'h0000_0000);
      9:  e = dmi_rd(DATA0);
      10: e = dmi_wr(COMMAND, 32'h0002_1000);
      11: e = dmi_rd(DATA0);
      12: e = dmi_rd(ABSTRACTCS);
      13: e = dmi_wr(DMCONTROL, 32'h4000_0001);
      14: e = dmi_wr(COMMAND, 32'h0002_1000);
      15: e = dmi_rd(ABSTRACTCS);
      16: e = dmi_wr(ABSTRACTCS, 32'h0000_0700);
      17: e = dmi_rd(ABSTRACTCS);
      18: e = dmi_wr(COMMAND, 32'h0100_0000);
      19: e = dmi_rd(ABSTRACTCS);
      20: e = dmi_wr(COMMAND, 32'h0002_1000);
      21: e = dmi_rd(ABSTRACTCS);
      22: e = dmi_wr(ABSTRACTCS, 32'h0000_0200);
      23: e = dmi_wr(DMCONTROL, 32'hC000_0001);
      24: e = dmi_wr(COMMAND, 32'h0002_0005);
      25: e = dmi_rd(ABSTRACTCS);
      26: e = dmi_wr(ABSTRACTCS, 32'h0000_0700);
      27: e = dmi_wr(DMCONTROL, 32'h4000_0001);
      28: e = dmi_wr(DMCONTROL, 32'h0020_0001);
      29: e = dmi_wr(DMCONTROL, 32'h8020_0001);
      30: e = dmi_rd(HALTSUM0);
      31: e = dmi_rd(DMSTATUS);
      32: e = dmi_wr(DMCONTROL, 32'h0021_0001);
      33: e = dmi_rd(DMSTATUS);
      34: e = dmi_wr(DMCONTROL, 32'h8021_0001);
      35: e = dmi_rd(HARTINFO);
      36: e = dmi_rd(7'h7F);
      37: e = dmi_rd(DMCONTROL);
      38: e = dmi_wr(DMCONTROL, 32'h0000_0003);
      39: e = dmi_rd(HALTSUM0);
      40: e = dmi_wr(DMCONTROL, 32'h8000_0003);
      41: e = dmi_rd(DMSTATUS);
      42: e = dmi_wr(DMCONTROL, 32'h0000_0001);
      43: e = dmi_wr(DMCONTROL, 32'h8000_0001);
      44: e = dmi_wr(DATA0, 32'h1234_5678);
      45: e = dmi_wr(COMMAND, 32'h0002_1000);
      46: e = dmi_rd(DATA0);
      48: begin
        e.op   = DMI_RSVD;
        e.addr = DATA0;
        e.data = 32'hFFFF_FFFF;
      end
      49: e = dmi_rd(DATA0);
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic dmi_is_rw(input logic [31:0] idx);
    dmi_entry_t e;
    e = dmi_program(idx);
    return (e.op == DMI_READ) || (e.op == DMI_WRITE);
  endfunction

endpackage

// File: rtl/dmi_dm.sv
// rtl/dmi_dm.sv - debug module register file and hart halt/scratch model
module dmi_dm
  import dmi_pkg::*;
#(
  parameter int WID           = 32,
  parameter int NUMBEROFCORES = 33
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic                     req_write_i,
  input  logic [6:0]               req_addr_i,
  input  logic [WID-1:0]           req_wdata_i,
  output logic [WID-1:0]           rdata_o,
  output logic [1:0]               rop_o,
  output logic [NUMBEROFCORES-1:0] halted_o
);

  localparam logic [10:0] NC = 11'(NUMBEROFCORES);

  logic [WID-1:0]           data0_q, data0_d;
  logic                     dmactive_q, dmactive_d;
  logic                     ndmreset_q, ndmreset_d;
  logic [9:0]               hartsel_q, hartsel_d;
  logic [2:0]               cmderr_q, cmderr_d;
  logic [NUMBEROFCORES-1:0] halted_q, halted_d;
  logic [WID-1:0]           scratch_q [NUMBEROFCORES];

  logic           wr_en, wr_dmc, wr_data0, wr_abscs, wr_cmd;
  logic [9:0]     wsel;
  logic           wsel_exists, sel_exists, sel_halted, scratch_wr;
  logic [WID-1:0] sel_scratch;
  logic [31:0]    haltsum;

  assign wr_en    = req_valid_i && req_write_i;
  assign wr_dmc   = wr_en && (req_addr_i == DMCONTROL);
  assign wr_data0 = wr_en && (req_addr_i == DATA0);
  assign wr_abscs = wr_en && (req_addr_i == ABSTRACTCS);
  assign wr_cmd   = wr_en && (req_addr_i == COMMAND);
  assign wsel        = req_wdata_i[25:16];
  assign wsel_exists = {1'b0, wsel} < NC;
  assign sel_exists  = {1'b0, hartsel_q} < NC;

  // Per-selected-hart views (halted flag, scratch register) and the haltsum0 window
  always_comb begin
    sel_halted  = 1'b0;
    sel_scratch = '0;
    haltsum     = '0;
    for (int i = 0; i < NUMBEROFCORES; i++) begin
      if (hartsel_q == 10'(i)) begin
        sel_halted  = halted_q[i];
        sel_scratch = scratch_q[i];
      end
    end
    for (int i = 0; i < 32 && i < NUMBEROFCORES; i++) begin
      haltsum[i] = halted_q[i];
    end
  end

  // Next-state for dmcontrol, hart halt flags, data0, cmderr and abstract command
  always_comb begin
    dmactive_d = dmactive_q;
    ndmreset_d = ndmreset_q;
    hartsel_d  = hartsel_q;
    halted_d   = halted_q;
    data0_d    = data0_q;
    cmderr_d   = cmderr_q;
    scratch_wr = 1'b0;

    if (wr_dmc) begin
      dmactive_d = req_wdata_i[0];
      // Inactive DM, or a write that deactivates it, leaves every other field cleared
      if (dmactive_q && req_wdata_i[0]) begin
        ndmreset_d = req_wdata_i[1];
        hartsel_d  = wsel;
        if (wsel_exists) begin
          for (int i = 0; i < NUMBEROFCORES; i++) begin
            if (wsel == 10'(i)) begin
              if (req_wdata_i[31])      halted_d[i] = 1'b1;
              else if (req_wdata_i[30]) halted_d[i] = 1'b0;
            end
          end
        end
      end else begin
        ndmreset_d = 1'b0;
        hartsel_d  = '0;
      end
    end
    // ndmreset takes effect on the same edge it is written and holds harts clear
    if (ndmreset_d) halted_d = '0;

    if (wr_data0) data0_d = req_wdata_i;
    if (wr_abscs) cmderr_d = cmderr_q & ~req_wdata_i[10:8];

    if (wr_cmd && (cmderr_q == CMDERR_NONE)) begin
      if (req_wdata_i[31:24] != 8'd0)                cmderr_d = CMDERR_NOTSUP;
      else if (!sel_halted)                          cmderr_d = CMDERR_HALTRESUME;
      else if (req_wdata_i[15:0] != REGNO_SCRATCH)   cmderr_d = CMDERR_EXCEPTION;
      else if (req_wdata_i[17]) begin
        if (req_wdata_i[16]) scratch_wr = 1'b1;
        else                 data0_d    = sel_scratch;
      end
    end
  end

  // Register read mux; unknown addresses read as zero
  always_comb begin
    rdata_o = '0;
    rop_o   = RESP_OK;
    if (req_valid_i && !req_write_i) begin
      case (req_addr_i)
        DATA0:      rdata_o = data0_q;
        DMCONTROL: begin
          rdata_o[0]     = dmactive_q;
          rdata_o[1]     = ndmreset_q;
          rdata_o[25:16] = hartsel_q;
        end
        DMSTATUS: begin
          rdata_o[3:0] = 4'd2;
          rdata_o[7]   = 1'b1;
          rdata_o[9]   = sel_halted;
          rdata_o[8]   = sel_halted;
          rdata_o[11]  = sel_exists && !sel_halted;
          rdata_o[10]  = sel_exists && !sel_halted;
          rdata_o[15]  = !sel_exists;
          rdata_o[14]  = !sel_exists;
        end
        ABSTRACTCS: begin
          rdata_o[3:0]  = 4'd1;
          rdata_o[10:8] = cmderr_q;
        end
        HALTSUM0:   rdata_o[31:0] = haltsum;
        default:    ;
      endcase
    end
  end

  // Control/status state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data0_q    <= '0;
      dmactive_q <= 1'b0;
      ndmreset_q <= 1'b0;
      hartsel_q  <= '0;
      cmderr_q   <= '0;
      halted_q   <= '0;
    end else begin
      data0_q    <= data0_d;
      dmactive_q <= dmactive_d;
      ndmreset_q <= ndmreset_d;
      hartsel_q  <= hartsel_d;
      cmderr_q   <= cmderr_d;
      halted_q   <= halted_d;
    end
  end

  // Per-hart scratch registers written by abstract transfer, cleared by ndmreset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUMBEROFCORES; i++) scratch_q[i] <= '0;
    end else if (ndmreset_d) begin
      for (int i = 0; i < NUMBEROFCORES; i++) scratch_q[i] <= '0;
    end else if (scratch_wr) begin
      for (int i = 0; i < NUMBEROFCORES; i++) begin
        if (hartsel_q == 10'(i)) scratch_q[i] <= data0_q;
      end
    end
  end

  assign halted_o = halted_q;

endmodule

// File: rtl/dmi_main.sv
// rtl/dmi_main.sv - DMI host sequencer replaying the program ROM into dmi_dm (trace macro: DMI_TRACE_EN)
module dmi_main
  import dmi_pkg::*;
#(
  parameter int LEN           = 128,
  parameter int WID           = 32,
  parameter int NUMBEROFCORES = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [NUMBEROFCORES-1:0] halted,
  output logic                     resp_valid,
  output logic [WID-1:0]           resp_data,
  output logic [1:0]               resp_op,
  output logic                     done
);

  localparam int IW = $clog2(LEN);
  localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);

  seq_state_e     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [WID-1:0] resp_data_q, resp_data_d;
  logic [1:0]     resp_op_q, resp_op_d;

  dmi_entry_t     cur;
  logic           cur_rw, nxt_rw;
  logic           req_valid;
  logic [WID-1:0] dm_rdata;
  logic [1:0]     dm_rop;

  assign cur    = dmi_program(32'(idx_q));
  assign cur_rw = dmi_is_rw(32'(idx_q));
  assign nxt_rw = dmi_is_rw(32'(idx_q) + 32'd1);

  // Sequencer next-state and outputs; nops bypass ISSUE/RESP
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    resp_data_d = resp_data_q;
    resp_op_d   = resp_op_q;
    req_valid   = 1'b0;
    resp_valid  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = cur_rw ? S_ISSUE : S_NEXT;
      S_ISSUE: begin
        req_valid   = 1'b1;
        resp_data_d = dm_rdata;
        resp_op_d   = dm_rop;
        state_d     = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_NEXT;
      end
      S_NEXT: begin
        idx_d = idx_q + 1'b1;
        if (idx_d == IDX_LAST) state_d = S_DONE;
        else                   state_d = nxt_rw ? S_ISSUE : S_NEXT;
      end
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      resp_data_q <= '0;
      resp_op_q   <= RESP_OK;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      resp_data_q <= resp_data_d;
      resp_op_q   <= resp_op_d;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_op   = resp_op_q;
  assign done      = (state_q == S_DONE);

  dmi_dm #(
    .WID           (WID),
    .NUMBEROFCORES (NUMBEROFCORES)
  ) u_dm (
    .clk_i       (clk),
    .rst_i       (reset),
    .req_valid_i (req_valid),
    .req_write_i (cur.op == DMI_WRITE),
    .req_addr_i  (cur.addr),
    .req_wdata_i (WID'(cur.data)),
    .rdata_o     (dm_rdata),
    .rop_o       (dm_rop),
    .halted_o    (halted)
  );

`ifdef DMI_TRACE_EN
  // Simulation trace of each completed response and of program completion
  always @(posedge clk) begin
    if (!reset && state_q == S_RESP)
      $display("DMI idx=%0d op=%0d addr=0x%02h wdata=0x%h rdata=0x%h resp_op=%0d",
               idx_q, cur.op, cur.addr, cur.data, resp_data_q, resp_op_q);
    if (!reset && state_q != S_DONE && state_d == S_DONE)
      $display("DMI program done");
  end
`endif

endmodule

// File: tb/tb_dmi_main.sv
// tb/tb_dmi_main.sv - directed self-checking bench for dmi_main
module tb_dmi_main;

  localparam int LEN   = 128;
  localparam int WID   = 32;
  localparam int NC    = 33;
  localparam int NRESP = 48;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] halted;
  logic          resp_valid;
  logic [WID-1:0] resp_data;
  logic [1:0]    resp_op;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  // Read data per response (writes return 0); entries 0..46 then entry 49
  logic [31:0] exp_data [NRESP] = '{
    32'h0, 32'h0, 32'h0, 32'h0, 32'h382, 32'h1, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h1, 32'h0, 32'h0, 32'h401,
    32'h0, 32'h1, 32'h0, 32'h201, 32'h0, 32'h201, 32'h0, 32'h0,
    32'h0, 32'h301, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h382,
    32'h0, 32'hC082, 32'h0, 32'h0, 32'h0, 32'h0021_0001, 32'h0, 32'h0,
    32'h0, 32'hC82, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
  };

  // Halted harts seen at each response: bit1 = hart 32, bit0 = hart 0
  logic [1:0] exp_hc [NRESP] = '{
    2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
    2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1,
    2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1
  };

  dmi_main #(
    .LEN           (LEN),
    .WID           (WID),
    .NUMBEROFCORES (NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .halted     (halted),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_op    (resp_op),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (halted !== '0)    begin n_bad++; $display("FAIL reset_halted: got %h want 0", halted); end
    n_cmp++; if (resp_valid !== 0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== '0) begin n_bad++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    n_cmp++; if (resp_op !== 2'd0) begin n_bad++; $display("FAIL reset_resp_op: got %0d want 0", resp_op); end
    n_cmp++; if (done !== 0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_program(input int nresp);
    logic [NC-1:0] eh;
    int exp_cyc;
    bit seen;
    for (int k = 0; k < nresp; k++) begin
      seen = 0;
      for (int w = 0; w < 300; w++) begin
        @(negedge clk);
        if (resp_valid === 1'b1) begin seen = 1; break; end
      end
      n_cmp++;
      if (!seen) begin
        n_bad++;
        $display("FAIL resp_timeout[%0d]: got no resp_valid want a response", k);
        return;
      end
      exp_cyc = (k < 47) ? 2 + 3 * k : 145;
      eh = '0;
      eh[0]  = exp_hc[k][0];
      eh[32] = exp_hc[k][1];
      n_cmp++; if (cyc !== exp_cyc) begin n_bad++; $display("FAIL resp_cycle[%0d]: got %0d want %0d", k, cyc, exp_cyc); end
      n_cmp++; if (resp_data !== exp_data[k]) begin n_bad++; $display("FAIL resp_data[%0d]: got %h want %h", k, resp_data, exp_data[k]); end
      n_cmp++; if (resp_op !== 2'd0) begin n_bad++; $display("FAIL resp_op[%0d]: got %0d want 0", k, resp_op); end
      n_cmp++; if (halted !== eh) begin n_bad++; $display("FAIL halted[%0d]: got %h want %h", k, halted, eh); end
    end
  endtask

  task automatic test_done();
    bit seen = 0;
    for (int w = 0; w < 400; w++) begin
      if (done === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_timeout: got done=%b want 1", done);
      return;
    end
    n_cmp++; if (cyc !== 224) begin n_bad++; $display("FAIL done_cycle: got %0d want 224", cyc); end
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b1)     begin n_bad++; $display("FAIL done_sticky: got %b want 1", done); end
      n_cmp++; if (resp_valid !== 0)  begin n_bad++; $display("FAIL done_quiet: got %b want 0", resp_valid); end
    end
    n_cmp++; if (halted !== {{(NC-1){1'b0}}, 1'b1}) begin n_bad++; $display("FAIL done_halted: got %h want 1", halted); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    #1;
    n_cmp++; if (done !== 0)       begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    n_cmp++; if (halted !== '0)    begin n_bad++; $display("FAIL mid_halted: got %h want 0", halted); end
    n_cmp++; if (resp_valid !== 0) begin n_bad++; $display("FAIL mid_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_data !== '0) begin n_bad++; $display("FAIL mid_resp_data: got %h want 0", resp_data); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_program(NRESP);
    test_done();
    test_reset_mid();
    test_program(10);
    test_reset_mid();
    test_program(NRESP);
    test_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmi_main.md
Name: dmi_main

Overview:
- Self-contained RISC-V debug-module subsystem (spec 0.13 subset).
- An internal DMI host sequencer replays a LEN-entry command program into a debug module (DM) that controls NUMBEROFCORES modelled harts.
- Top level of the debugger dev tree; needs only clock and reset, and exposes observation outputs for waveform dump or ILA.

Parameters:
- LEN, 128, number of entries in the DMI command program ROM.
- WID, 32, DMI data width and abstract-register width.
- NUMBEROFCORES, 33, number of modelled harts; must be 1..1024.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state.
- halted  output  NUMBEROFCORES  per-hart halted flags.
- resp_valid  output  1  one-cycle pulse when a DMI response completes.
- resp_data  output  WID  read data of the last response.
- resp_op  output  2  response status: 0 = ok, 2 = failed.
- done  output  1  high once the whole program has executed; sticky until reset.

Behaviour:
- Reset values: all outputs 0; sequencer in IDLE with idx = 0; every DM register 0; all harts running.
- ROM entry format: {op[1:0], addr[6:0], data[WID-1:0]}.
  - op: 0 = nop, 1 = read, 2 = write, 3 = reserved, treated as nop.
  - Program content is a constant function in the package; entries past the defined program are nops.
- Sequencer FSM:
  - IDLE to ISSUE on the first cycle after reset deasserts.
  - ISSUE drives the request to the DM for 1 cycle, then RESP.
  - RESP: resp_valid = 1 for 1 cycle, then NEXT.
  - NEXT: idx++. If idx == LEN-1, go to DONE; else ISSUE.
  - Nops skip ISSUE/RESP: NEXT directly, no resp_valid.
  - DONE holds forever with done = 1.
  - Latency: 3 cycles per read/write entry.
- DM registers (addr, behaviour):
  - 0x04 data0: RW, WID bits.
  - 0x10 dmcontrol:
    - Fields: bit0 dmactive, bit1 ndmreset, bit31 haltreq, bit30 resumereq, bits25:16 hartsello.
    - While dmactive = 0, writes update only dmactive; all other fields read 0.
  - 0x11 dmstatus: RO.
    - version = 2 in bits 3:0; authenticated bit7 = 1.
    - any/allhalted bits 9/8, any/allrunning bits 11/10, any/allnonexistent bits 15/14.
    - All reflect the selected hart only.
    - Nonexistent when hartsel >= NUMBEROFCORES; then halted/running bits are 0.
  - 0x12 hartinfo: RO, reads 0.
  - 0x16 abstractcs:
    - datacount = 1 in bits 3:0; cmderr in bits 10:8; busy bit12 always reads 0.
    - Writing 1s to cmderr bits clears those bits (W1C).
  - 0x17 command: WO.
  - 0x40 haltsum0: RO, halted[31:0], zero-extended.
  - Any other address: read returns 0 with op 0; write ignored with op 0.
- Hart model:
  - A dmcontrol write with haltreq = 1 sets halted[hartsel] on the next cycle.
  - resumereq = 1 with haltreq = 0 clears it on the next cycle.
  - If both are set, haltreq wins.
  - ndmreset = 1 clears all halted bits and all hart scratch registers, and holds them clear.
  - Nonexistent hartsel: halt and resume are ignored.
- Abstract command write:
  - Word format: cmdtype bits 31:24, write bit16, transfer bit17, regno bits 15:0.
  - Applied only when cmderr == 0; otherwise ignored.
  - cmdtype != 0: cmderr = 2.
  - Selected hart not halted or nonexistent: cmderr = 4.
  - Otherwise, with transfer = 1 and regno == 0x1000 (x0 alias scratch):
    - write = 1: scratch[hartsel] <= data0.
    - write = 0: data0 <= scratch[hartsel].
  - Any other regno: cmderr = 3.
  - Completes in 1 cycle.
- Simultaneous events: reset mid-operation aborts the current entry; the program restarts from idx 0 after release.

Optional Feature:
- Macro DMI_TRACE_EN.
- When defined: a simulation-only $display at each resp_valid showing idx, op, addr, wdata, rdata and resp_op; a $display "DMI program done" on entering DONE.
- When undefined: no trace code compiled; RTL is otherwise identical.

Decomposition:
- Package dmi_pkg holds:
  - DM address constants (DATA0, DMCONTROL, DMSTATUS, HARTINFO, ABSTRACTCS, COMMAND, HALTSUM0).
  - DMI op encodings and the cmderr codes.
  - The ROM-entry struct/typedef.
  - The program-content function.
- One sub-module, dmi_dm: the DM register file plus hart model.
- dmi_main contains the sequencer and ROM and instantiates dmi_dm.

Test Plan:
- Reset with no further stimulus -> all outputs 0 and halted = 0; after release, the first resp_valid appears on cycle 3.
- Program: write dmcontrol = 0x1, write 0x8000_0001 (halt hart 0), read dmstatus -> resp_data bits 9/8 = 1 and version = 2; haltsum0 reads 0x1.
- Select hart 32 (0x0020_0001), halt, read haltsum0 -> 0 with halted[32] = 1; select hart 33 -> dmstatus bits 15/14 = 1.
- Hart 0 halted: write data0 = 0xDEAD_BEEF, command 0x0003_1000, clear data0, command 0x0002_1000 -> data0 reads 0xDEAD_BEEF.
- Command to a running hart -> abstractcs cmderr = 4; write abstractcs 0x700 -> cmderr reads 0; cmdtype = 1 -> cmderr = 2.
- Run to end -> done = 1 exactly once program idx reaches LEN-1; assert reset mid-program -> done = 0 and replay from idx 0.
